// File: rtl/segment_packer.sv
// Packs 16-bit pipe words (MSB first) into 128-bit clock segments and holds one for the segment FIFO.
// Optional zero-period rejection is enabled by defining SEGMENT_CHECK_EN.
module segment_packer #(
    parameter int SEG_COUNT_W = 16
) (
    input  logic                   ti_clk,
    input  logic                   reset,
    input  logic                   pipe_write,
    input  logic [15:0]            pipe_data,
    input  logic                   flush,
    input  logic                   status_clr,
    input  logic                   fifo_full,
    output logic [127:0]           seg_data,
    output logic                   seg_write,
    output logic                   busy,
    output logic [2:0]             word_idx,
    output logic [SEG_COUNT_W-1:0] seg_count,
    output logic                   overflow,
    output logic                   err_zero_period
);

    logic [127:0]           shift_q, shift_d;
    logic [127:0]           hold_q, hold_d;
    logic [2:0]             idx_q, idx_d;
    logic                   busy_q, busy_d;
    logic [SEG_COUNT_W-1:0] count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   err_q, err_d;

    logic [127:0] assembled;
    logic         accept;
    logic         complete;
    logic         bad_seg;
    logic         load;
    logic         write_now;

    assign accept    = pipe_write & ~flush;
    assign complete  = accept & (idx_q == 3'd7);
    assign assembled = {shift_q[111:0], pipe_data};
    assign write_now = busy_q & ~fifo_full & ~flush;

`ifdef SEGMENT_CHECK_EN
    logic [48:0] period_sum;
    assign period_sum = {1'b0, assembled[127:80]} + {1'b0, assembled[79:32]};
    assign bad_seg    = (assembled[31:0] != 32'd0) && (period_sum == 49'd0);
`else
    assign bad_seg    = 1'b0;
`endif

    // A completion while a segment is still held only lands if the held one leaves this cycle.
    assign load = complete & ~bad_seg & (~busy_q | write_now);

    always_comb begin
        shift_d    = shift_q;
        hold_d     = hold_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        err_d      = err_q;

        if (flush) begin
            shift_d = '0;
            hold_d  = '0;
            idx_d   = 3'd0;
            busy_d  = 1'b0;
        end else begin
            if (accept) begin
                shift_d = assembled;
                idx_d   = idx_q + 3'd1;
            end
            if (load) begin
                hold_d = assembled;
                busy_d = 1'b1;
            end else if (write_now) begin
                busy_d = 1'b0;
            end
        end

        if (status_clr) begin
            overflow_d = 1'b0;
            err_d      = 1'b0;
            count_d    = '0;
        end
        // Set events are applied after the clear so they win in the same cycle.
        if (write_now && (count_d != '1))
            count_d = count_d + 1'b1;
        if (complete && !bad_seg && busy_q && !write_now)
            overflow_d = 1'b1;
        if (complete && bad_seg)
            err_d = 1'b1;
    end

    always_ff @(posedge ti_clk) begin
        if (reset) begin
            shift_q    <= '0;
            hold_q     <= '0;
            idx_q      <= 3'd0;
            busy_q     <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
        end
    end

    assign seg_data        = hold_q;
    assign seg_write       = write_now;
    assign busy            = busy_q;
    assign word_idx        = idx_q;
    assign seg_count       = count_q;
    assign overflow        = overflow_q;
`ifdef SEGMENT_CHECK_EN
    assign err_zero_period = err_q;
`else
    assign err_zero_period = 1'b0;
`endif

endmodule

// File: tb/tb_segment_packer.sv
// Directed bench for segment_packer: packing, hold/overflow, flush, zero-period check and reset.
module tb_segment_packer;

    logic         ti_clk = 1'b0;
    logic         reset, pipe_write, flush, status_clr, fifo_full;
    logic [15:0]  pipe_data;
    logic [127:0] seg_data;
    logic         seg_write, busy, overflow, err_zero_period;
    logic [2:0]   word_idx;
    logic [15:0]  seg_count;

    int n_pass  = 0;
    int n_total = 0;
    logic [127:0] wr_q[$];

    segment_packer #(.SEG_COUNT_W(16)) dut (
        .ti_clk(ti_clk), .reset(reset), .pipe_write(pipe_write), .pipe_data(pipe_data),
        .flush(flush), .status_clr(status_clr), .fifo_full(fifo_full),
        .seg_data(seg_data), .seg_write(seg_write), .busy(busy), .word_idx(word_idx),
        .seg_count(seg_count), .overflow(overflow), .err_zero_period(err_zero_period)
    );

    always #5 ti_clk = ~ti_clk;

    // Record every segment handed to the FIFO.
    always @(posedge ti_clk)
        if (!reset && seg_write) wr_q.push_back(seg_data);

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s = 0x%0h", tag, got);
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ti_clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] d);
        pipe_write = 1'b1;
        pipe_data  = d;
        tick();
        pipe_write = 1'b0;
    endtask

    task automatic send_seg(input logic [127:0] s);
        for (int i = 0; i < 8; i++) send_word(s[127 - 16*i -: 16]);
    endtask

    task automatic clear_status();
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int n, input logic [127:0] exp);
        check({tag, "_n"}, 128'(wr_q.size()), 128'(n));
        if (wr_q.size() > 0) check({tag, "_data"}, wr_q[0], exp);
        wr_q.delete();
    endtask

    localparam logic [127:0] SEG1  = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
    localparam logic [127:0] SEG_A = 128'hAAAA_0001_1111_BBBB_0002_2222_0000_0005;
    localparam logic [127:0] SEG_B = 128'h1234_5678_9ABC_DEF0_1357_9BDF_0000_0009;
    localparam logic [127:0] SEG_Z = 128'h0000_0000_0000_0000_0000_0000_0000_0003;
    localparam logic [127:0] SEG_0 = 128'h0000_0000_0000_0000_0000_0000_0000_0000;

    initial begin
        reset = 1'b1; pipe_write = 1'b0; pipe_data = 16'h0; flush = 1'b0;
        status_clr = 1'b0; fifo_full = 1'b0;
        tick(); tick();
        check("rst_seg_data", seg_data, 128'h0);
        check("rst_outputs", {seg_write, busy, word_idx, overflow, err_zero_period}, 0);
        check("rst_count", seg_count, 0);
        reset = 1'b0;
        tick();

        // Basic packing, MSB word first
        send_seg(SEG1);
        check("t1_busy", busy, 1);
        check("t1_seg_data", seg_data, SEG1);
        check("t1_seg_write", seg_write, 1);
        check("t1_word_idx", word_idx, 0);
        tick();
        check_writes("t1_wr", 1, SEG1);
        check("t1_count", seg_count, 1);
        check("t1_busy_after", busy, 0);

        // Full FIFO: second completion is dropped
        clear_status();
        fifo_full = 1'b1;
        send_seg(SEG_A);
        send_seg(SEG_B);
        check("t2_busy", busy, 1);
        check("t2_seg_write", seg_write, 0);
        check("t2_overflow", overflow, 1);
        check("t2_held", seg_data, SEG_A);
        fifo_full = 1'b0;
        tick(); tick();
        check_writes("t2_wr", 1, SEG_A);
        check("t2_count", seg_count, 1);

        // Drain and completion in the same cycle
        clear_status();
        fifo_full = 1'b1;
        send_seg(SEG_A);
        for (int i = 0; i < 7; i++) send_word(SEG_B[127 - 16*i -: 16]);
        pipe_write = 1'b1;
        pipe_data  = SEG_B[15:0];
        fifo_full  = 1'b0;
        #1;
        check("t3_write_same", seg_write, 1);
        @(posedge ti_clk); #1;
        pipe_write = 1'b0;
        check("t3_busy", busy, 1);
        check("t3_held_b", seg_data, SEG_B);
        check("t3_overflow", overflow, 0);
        check("t3_wr_count_a", 128'(wr_q.size()), 1);
        if (wr_q.size() > 0) check("t3_wr_a", wr_q[0], SEG_A);
        wr_q.delete();
        tick();
        check_writes("t3_wr_b", 1, SEG_B);
        check("t3_count", seg_count, 2);

        // Flush of a partial segment
        clear_status();
        for (int i = 0; i < 5; i++) send_word(16'hDEAD);
        check("t4_idx_pre", word_idx, 5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_idx_post", word_idx, 0);
        send_seg(SEG1);
        tick();
        check_writes("t4_wr", 1, SEG1);

        // Zero-period segment, then the same with repeat=0
        clear_status();
        send_seg(SEG_Z);
        tick();
`ifdef SEGMENT_CHECK_EN
        check_writes("t5_zero", 0, SEG_Z);
        check("t5_err", err_zero_period, 1);
`else
        check_writes("t5_zero", 1, SEG_Z);
        check("t5_err", err_zero_period, 0);
`endif
        send_seg(SEG_0);
        tick();
        check_writes("t5_rep0", 1, SEG_0);

        // Reset during word 4
        for (int i = 0; i < 4; i++) send_word(16'hBEEF);
        reset = 1'b1;
        pipe_write = 1'b1;
        pipe_data = 16'hBEEF;
        tick();
        reset = 1'b0;
        pipe_write = 1'b0;
        check("t6_seg_data", seg_data, 128'h0);
        check("t6_outputs", {seg_write, busy, word_idx, overflow, err_zero_period}, 0);
        check("t6_count", seg_count, 0);
        wr_q.delete();
        send_seg(SEG_B);
        tick();
        check_writes("t6_wr", 1, SEG_B);
        check("t6_count_after", seg_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/segment_packer.md
# segment_packer

Assembles the 16-bit host pipe stream into 128-bit clock segments {on_counts[47:0], off_counts[47:0], repeat_counts[31:0]} and writes them, one per handshake, into the segment FIFO that feeds the variable-frequency clock generator. It sits between the Opal Kelly pipe-in endpoint (0x80) and the FIFO write port, entirely in the ti_clk domain. It holds one completed segment while the FIFO is full, optionally rejects malformed segments, and keeps sticky status for host readback over wire-outs.

## Interface
- SEG_COUNT_W, 16, width of accepted-segment counter
- ti_clk  in  1  host interface clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- pipe_write  in  1  pipe word strobe, one word per asserted cycle
- pipe_data  in  16  pipe word
- flush  in  1  discard partial segment and held segment (abort path)
- status_clr  in  1  clear sticky flags and counters
- fifo_full  in  1  segment FIFO full
- seg_data  out  128  held segment; on_counts = [127:80], off_counts = [79:32], repeat_counts = [31:0]
- seg_write  out  1  FIFO write enable
- busy  out  1  a completed segment is held awaiting FIFO space
- word_idx  out  3  index of next expected word in current segment
- seg_count  out  SEG_COUNT_W  segments written to FIFO, saturating
- overflow  out  1  sticky: completed segment dropped because one was already held
- err_zero_period  out  1  sticky: segment rejected by check

## Operation
- Word order MSB first: word 0 -> seg[127:112], ..., word 7 -> seg[15:0]. Shift register plus 3-bit word_idx; idx wraps 7 -> 0 on completion.
- Completion (pipe_write with word_idx==7): the assembled 128 bits are checked, then loaded into the hold register (busy=1).
- Check (SEGMENT_CHECK_EN only): reject if repeat_counts!=0 and on_counts+off_counts==0 (49-bit sum, no truncation). A rejected segment is not loaded, err_zero_period is set, and word_idx still wraps to 0. repeat_counts==0 (wait-for-retrigger) is always legal.
- seg_write = busy & ~fifo_full (combinational from the registered busy). In a cycle with seg_write=1, busy clears at the next edge, seg_count increments (saturating at all-ones).
- Completion while busy=1 and no write that cycle: the new segment is dropped and overflow is set. Completion in the same cycle as seg_write=1: the new segment replaces the held one, busy stays 1, no overflow.
- flush: word_idx<=0, busy<=0, shift register cleared. It overrides pipe_write in the same cycle. seg_write is forced 0 that cycle. Stickies and seg_count are unaffected.
- status_clr: overflow<=0, err_zero_period<=0, seg_count<=0. A set event in the same cycle wins over the clear.
- reset: all outputs 0 (seg_data=0, seg_write=0, busy=0, word_idx=0, seg_count=0, both stickies 0). Reset mid-segment discards partial data.

## Timing
- Last word on edge n -> busy=1 and seg_data valid after edge n. seg_write is asserted during cycle n+1 if fifo_full=0, so best-case latency is 1 cycle.
- Sustained rate: one segment per 8 pipe words. No back-pressure to the pipe; loss is reported only by overflow.
- fifo_full is sampled combinationally each cycle. seg_data is stable whenever busy=1 and changes only on completion, flush or reset.
- word_idx updates at the edge following each accepted pipe_write.

## Configuration
- SEGMENT_CHECK_EN defined: the zero-period check is active as described.
- SEGMENT_CHECK_EN undefined: every completed segment is loaded; err_zero_period is tied 0 and its logic is removed.

## Test plan
- Write 8 words 0x0001..0x0008 with fifo_full=0 -> one seg_write, seg_data = 0x0001_0002_0003_0004_0005_0006_0007_0008, seg_count=1, word_idx=0.
- fifo_full=1, send segment A then segment B -> busy=1, no seg_write, overflow=1, held data = A. Deassert full -> single seg_write with A, seg_count=1.
- Hold segment A with full=1; drop full in the same cycle that B's last word arrives -> A written, B held, overflow=0, then B written next cycle, seg_count=2.
- Send 5 words, flush, then 8 new words -> exactly one segment, made only of the new words; word_idx=5 before the flush and 0 after it.
- Segment with on=0, off=0, repeat=3 -> with macro: no write, err_zero_period=1; without macro: written, flag 0. Same segment with repeat=0 -> written in both builds.
- Assert reset during word 4 -> all outputs 0 next cycle; the following 8 words produce one correct segment.
